// File: rtl/mcg_pkg.sv
// multi_clk_gen shared types: channel state, config set, clamp.
// Build option: MCG_RISE_STROBE_EN adds the rise_o strobe output.
package mcg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RUN
  } mcg_state_e;

  localparam int unsigned DEF_P = 2;
  localparam int unsigned DEF_H = 1;
  localparam int unsigned DEF_D = 0;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic [31:0] d;
  } mcg_cfg_t;

  // Force a usable waveform: P >= 2 and 1 <= H <= P-1.
  function automatic mcg_cfg_t mcg_clamp(
    input mcg_cfg_t c
  );
    mcg_cfg_t r;
    r = c;
    if (c.p < 32'd2) r.p = 32'd2;
    if (r.h == 32'd0) r.h = 32'd1;
    else if (r.h >= r.p) r.h = r.p - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/mcg_channel.sv
// multi_clk_gen single channel: shadow/active sets, FSM, counter.
// Build option: MCG_RISE_STROBE_EN adds the rise_o strobe output.
module mcg_channel
  import mcg_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
  input  logic [CW-1:0] cfg_phase,
  output logic          clk_o,
  output logic          running
`ifdef MCG_RISE_STROBE_EN
  ,
  output logic          rise_o
`endif
);

  mcg_state_e    st, st_n;
  logic [CW-1:0] sh_p, sh_h, sh_d;
  logic [CW-1:0] ac_p, ac_h;
  logic [CW-1:0] ac_p_n, ac_h_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          clk_q, clk_n;
  logic          run_q, run_n;
  mcg_cfg_t      src, cl;

  // Pick the set being activated, bypassing a same-cycle write.
  always_comb begin
    src = '0;
    if (wr) begin
      src.p = 32'(cfg_period);
      src.h = 32'(cfg_high);
      src.d = 32'(cfg_phase);
    end else begin
      src.p = 32'(sh_p);
      src.h = 32'(sh_h);
      src.d = 32'(sh_d);
    end
    cl = mcg_clamp(src);
  end

  assign cnt_inc = cnt + CW'(1);

  // Next-state, counter and output decode.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    clk_n  = clk_q;
    ac_p_n = ac_p;
    ac_h_n = ac_h;
    unique case (st)
      ST_IDLE: begin
        clk_n = 1'b0;
        if (en) begin
          ac_p_n = CW'(cl.p);
          ac_h_n = CW'(cl.h);
          cnt_n  = CW'(cl.d);
          st_n   = ST_DELAY;
        end
      end
      ST_DELAY: begin
        clk_n = 1'b0;
        if (cnt == '0) begin
          st_n  = ST_RUN;
          clk_n = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_RUN: begin
        if (cnt == ac_p - CW'(1)) begin
          ac_p_n = CW'(cl.p);
          ac_h_n = CW'(cl.h);
          cnt_n  = '0;
          if (en) begin
            clk_n = 1'b1;
          end else begin
            clk_n = 1'b0;
            st_n  = ST_IDLE;
          end
        end else begin
          cnt_n = cnt_inc;
          clk_n = (cnt_inc < ac_h);
        end
      end
      default: begin
        st_n  = ST_IDLE;
        clk_n = 1'b0;
        cnt_n = '0;
      end
    endcase
    run_n = (st_n != ST_IDLE);
  end

  // Shadow set captures every write to this channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p <= CW'(DEF_P);
      sh_h <= CW'(DEF_H);
      sh_d <= CW'(DEF_D);
    end else if (wr) begin
      sh_p <= cfg_period;
      sh_h <= cfg_high;
      sh_d <= cfg_phase;
    end
  end

  // State, active set, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      ac_p  <= CW'(DEF_P);
      ac_h  <= CW'(DEF_H);
      cnt   <= '0;
      clk_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      st    <= st_n;
      ac_p  <= ac_p_n;
      ac_h  <= ac_h_n;
      cnt   <= cnt_n;
      clk_q <= clk_n;
      run_q <= run_n;
    end
  end

  assign clk_o   = clk_q;
  assign running = run_q;

`ifdef MCG_RISE_STROBE_EN
  logic rise_q;

  // Strobe marks the cycle in which clk_o first reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rise_q <= 1'b0;
    else        rise_q <= clk_n & ~clk_q;
  end

  assign rise_o = rise_q;
`endif

endmodule

// File: rtl/multi_clk_gen.sv
// multi_clk_gen top: NCH programmable divided clocks.
// Build option: MCG_RISE_STROBE_EN adds the rise_o strobe output.
module multi_clk_gen
  import mcg_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int CW  = 16,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] en,
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic [CW-1:0]  cfg_high,
  input  logic [CW-1:0]  cfg_phase,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] running
`ifdef MCG_RISE_STROBE_EN
  ,
  output logic [NCH-1:0] rise_o
`endif
);

  logic [NCH-1:0] wr;

  // Write-address decode; out-of-range channels match nothing.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_wr && (cfg_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mcg_channel #(
      .CW(CW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[g]),
      .wr        (wr[g]),
      .cfg_period(cfg_period),
      .cfg_high  (cfg_high),
      .cfg_phase (cfg_phase),
      .clk_o     (clk_o[g]),
      .running   (running[g])
`ifdef MCG_RISE_STROBE_EN
      ,
      .rise_o    (rise_o[g])
`endif
    );
  end

endmodule

// File: tb/tb_multi_clk_gen.sv
// multi_clk_gen bench: directed vectors, queued expectations.
// Build option: MCG_RISE_STROBE_EN enables rise_o checks.
module tb_multi_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  en = '0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_high = '0;
  logic [15:0] cfg_phase = '0;
  logic [3:0]  clk_o;
  logic [3:0]  running;
`ifdef MCG_RISE_STROBE_EN
  logic [3:0]  rise_o;
`endif

  multi_clk_gen #(
    .NCH(4),
    .CW (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_wr    (cfg_wr),
    .cfg_ch    (cfg_ch),
    .cfg_period(cfg_period),
    .cfg_high  (cfg_high),
    .cfg_phase (cfg_phase),
    .clk_o     (clk_o),
    .running   (running)
`ifdef MCG_RISE_STROBE_EN
    ,
    .rise_o    (rise_o)
`endif
  );

  always #5 clk = ~clk;

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  typedef struct {
    int    stamp;
    int    ch;
    int    kind;
    logic  val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int n_run = 0;
  int n_fail = 0;

  function automatic void cmp(string nm, int st, logic act, logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %b, expected %b", nm, st, act, exp);
    end
  endfunction

  function automatic logic pick(int kind, int ch);
    logic v;
    v = 1'b0;
    case (kind)
      0: v = clk_o[ch];
      1: v = running[ch];
`ifdef MCG_RISE_STROBE_EN
      2: v = rise_o[ch];
`endif
      default: v = 1'bx;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].stamp == pe) begin
        cmp(sbq[i].name, pe, pick(sbq[i].kind, sbq[i].ch), sbq[i].val);
        sbq.delete(i);
      end else if (sbq[i].stamp < pe) begin
        n_run++;
        n_fail++;
        $display("FAIL %s missed edge %0d", sbq[i].name, sbq[i].stamp);
        sbq.delete(i);
      end
    end
  end

  task automatic push(int st, int ch, int kind, logic v, string nm);
    exp_t e;
    e.stamp = st;
    e.ch    = ch;
    e.kind  = kind;
    e.val   = v;
    e.name  = nm;
    sbq.push_back(e);
  endtask

  task automatic exp_wave(int ch, int e0, int hi, int lo, int nper,
                          string nm);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < hi + lo; i++) begin
        push(e0 + p * (hi + lo) + i, ch, 0, (i < hi), nm);
      end
    end
  endtask

  task automatic cfg(int ch, int p, int h, int d);
    cfg_ch     = 2'(ch);
    cfg_period = 16'(p);
    cfg_high   = 16'(h);
    cfg_phase  = 16'(d);
    cfg_wr     = 1'b1;
    @(negedge clk);
    cfg_wr     = 1'b0;
  endtask

  task automatic wait_edge(int n);
    while (pe < n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      cmp("rst_clk_o", pe, clk_o[c], 1'b0);
      cmp("rst_running", pe, running[c], 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // ch0 P4 H2 D0 and ch1 P10 H3 D5 started together
    cfg(0, 4, 2, 0);
    cfg(1, 10, 3, 5);
    en = 4'b0011;
    k = pe + 1;
    push(k, 0, 1, 1'b1, "ch0_running");
    push(k, 1, 1, 1'b1, "ch1_running");
    push(k, 0, 0, 1'b0, "ch0_delay");
    for (int i = 0; i < 6; i++) push(k + i, 1, 0, 1'b0, "ch1_delay");
    exp_wave(0, k + 1, 2, 2, 4, "ch0_p4");
    exp_wave(1, k + 6, 3, 7, 2, "ch1_p10");
    exp_wave(0, k + 17, 3, 3, 1, "ch0_p6");
    exp_wave(0, k + 23, 3, 3, 1, "ch0_last");
    push(k + 28, 0, 1, 1'b1, "ch0_run_bnd");
    push(k + 29, 0, 1, 1'b0, "ch0_run_off");
    for (int i = 29; i < 35; i++) push(k + i, 0, 0, 1'b0, "ch0_idle");
    wait_edge(k + 13);
    cfg(0, 6, 3, 0);
    wait_edge(k + 23);
    en[0] = 1'b0;
    drain();
    en = '0;

    // clamped settings on ch2 and ch3
    cfg(2, 1, 0, 0);
    cfg(3, 5, 9, 0);
    en[3:2] = 2'b11;
    k = pe + 1;
    exp_wave(2, k + 1, 1, 1, 4, "clamp_p1h0");
    exp_wave(3, k + 1, 4, 1, 3, "clamp_p5h9");
    drain();

    // write bypass on activation: ch0 P3 H1 D2
    cfg_ch     = 2'd0;
    cfg_period = 16'd3;
    cfg_high   = 16'd1;
    cfg_phase  = 16'd2;
    cfg_wr     = 1'b1;
    en[0]      = 1'b1;
    k = pe + 1;
    push(k, 0, 1, 1'b1, "byp_running");
    for (int i = 0; i < 3; i++) push(k + i, 0, 0, 1'b0, "byp_delay");
    exp_wave(0, k + 3, 1, 2, 3, "byp_p3");
`ifdef MCG_RISE_STROBE_EN
    for (int i = 0; i < 12; i++) begin
      push(k + i, 0, 2, (i >= 3) && ((i - 3) % 3 == 0), "rise_p3");
    end
`endif
    @(negedge clk);
    cfg_wr = 1'b0;
    drain();

    // asynchronous reset while ch0, ch2, ch3 run
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      cmp("arst_clk_o", pe, clk_o[c], 1'b0);
      cmp("arst_running", pe, running[c], 1'b0);
    end
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // defaults after reset: P2 H1 D0
    en[0] = 1'b1;
    k = pe + 1;
    push(k, 0, 1, 1'b1, "dflt_running");
    push(k, 0, 0, 1'b0, "dflt_delay");
    exp_wave(0, k + 1, 1, 1, 3, "dflt_p2");
    drain();
    en = '0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
